mdu_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit that sits beside the ALU in the EX stage. It takes over the HI/LO class of operations: MULT, MULTU, DIV, DIVU, MTHI and MTLO. Results are held in internal HI/LO registers and the pipeline is told to stall via `busy`. Operand width and per-operation latency are parameters, so one unit serves the 32-bit core and narrower test configurations.

---
 rtl/mdu_if.sv | 16 +
 rtl/mdu_unit.sv | 137 +++++++++++++
 tb/tb_mdu_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// Issue/result bundle between the EX stage and the HI/LO multiply-divide unit.
interface mdu_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output start, op, A, B, input busy, done, HI, LO);
  modport slave  (input start, op, A, B, output busy, done, HI, LO);
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit: the result is computed at issue,
// held in pending registers, and committed to HI/LO after a fixed busy latency.
module mdu_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_pend_hi, r_pend_lo, r_hi, r_lo;
  logic             r_busy, r_done;

  logic signed [WIDTH-1:0]   w_a_s, w_b_s, w_q_s, w_r_s;
  logic [WIDTH-1:0]          w_q_u, w_r_u;
  logic [2*WIDTH-1:0]        w_prod_s, w_prod_u;
  logic                      w_b_zero, w_ovf, w_long;
  logic [WIDTH-1:0]          w_hi_n, w_lo_n;
  logic [CW-1:0]             w_lat;

  assign w_a_s    = bus.A;
  assign w_b_s    = bus.B;
  // Low 2*WIDTH bits of the sign-extended product equal the signed product.
  assign w_prod_s = {{WIDTH{bus.A[WIDTH-1]}}, bus.A} * {{WIDTH{bus.B[WIDTH-1]}}, bus.B};
  assign w_prod_u = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
  assign w_q_s    = w_a_s / w_b_s;
  assign w_r_s    = w_a_s % w_b_s;
  assign w_q_u    = bus.A / bus.B;
  assign w_r_u    = bus.A % bus.B;
  assign w_b_zero = (bus.B == '0);
  assign w_ovf    = (bus.A == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.B == '1);

  always_comb begin
    w_hi_n = '0;
    w_lo_n = '0;
    w_long = 1'b0;
    w_lat  = '0;
    case (bus.op)
      3'b000: begin
        w_hi_n = w_prod_s[2*WIDTH-1:WIDTH];
        w_lo_n = w_prod_s[WIDTH-1:0];
        w_long = 1'b1;
        w_lat  = CW'(MUL_CYCLES - 1);
      end
      3'b001: begin
        w_hi_n = w_prod_u[2*WIDTH-1:WIDTH];
        w_lo_n = w_prod_u[WIDTH-1:0];
        w_long = 1'b1;
        w_lat  = CW'(MUL_CYCLES - 1);
      end
      3'b010: begin
        w_long = 1'b1;
        w_lat  = CW'(DIV_CYCLES - 1);
        if (w_b_zero) begin
          w_hi_n = bus.A;
          w_lo_n = '1;
        end else if (w_ovf) begin
          w_hi_n = '0;
          w_lo_n = bus.A;
        end else begin
          w_hi_n = w_r_s;
          w_lo_n = w_q_s;
        end
      end
      3'b011: begin
        w_long = 1'b1;
        w_lat  = CW'(DIV_CYCLES - 1);
        if (w_b_zero) begin
          w_hi_n = bus.A;
          w_lo_n = '1;
        end else begin
          w_hi_n = w_r_u;
          w_lo_n = w_q_u;
        end
      end
      default: ;
    endcase
  end

  // Counter is loaded with latency-1 so commit lands exactly N edges after issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_long) begin
              r_pend_hi <= w_hi_n;
              r_pend_lo <= w_lo_n;
              r_cnt     <= w_lat;
              r_busy    <= 1'b1;
              r_state   <= S_RUN;
            end else if (bus.op == 3'b100) begin
              r_hi <= bus.A;
            end else if (bus.op == 3'b101) begin
              r_lo <= bus.A;
            end
          end
        end
        S_RUN: begin
          if (r_cnt == '0) begin
            r_hi    <= r_pend_hi;
            r_lo    <= r_pend_lo;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;
endmodule

// File: tb/tb_mdu_unit.sv
// Directed-vector bench for mdu_unit: a 32-bit default instance and an 8-bit,
// single-cycle-multiply instance sharing clock and reset.
module tb_mdu_unit;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  mdu_if #(.WIDTH(32)) bus ();
  mdu_if #(.WIDTH(8))  bus8 ();

  mdu_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  mdu_unit #(.WIDTH(8), .MUL_CYCLES(1), .DIV_CYCLES(10)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output logic dn);
    bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
    @(posedge clk); #1 bus.start = 1'b0;
    cyc = 0; dn = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy) cyc++;
      else begin dn = bus.done; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.HI !== 32'h0 || bus.LO !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state got busy=%b done=%b HI=%h LO=%h want 0/0/0/0",
               bus.busy, bus.done, bus.HI, bus.LO);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_multu();
    int c; logic d;
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, c, d);
    vectors++;
    if (c !== 5 || d !== 1'b1) begin
      miscompares++; $display("FAIL multu_busy got cycles=%0d done=%b want 5/1", c, d);
    end
    vectors++;
    if (bus.HI !== 32'hFFFFFFFE || bus.LO !== 32'h00000001) begin
      miscompares++; $display("FAIL multu_result got %h_%h want fffffffe_00000001", bus.HI, bus.LO);
    end
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++; $display("FAIL multu_done_pulse got done=%b want 0", bus.done);
    end
  endtask

  task automatic test_mult();
    int c; logic d;
    run_op(3'b000, 32'hFFFFFFFD, 32'd7, c, d);
    vectors++;
    if (c !== 5 || d !== 1'b1 || bus.HI !== 32'hFFFFFFFF || bus.LO !== 32'hFFFFFFEB) begin
      miscompares++;
      $display("FAIL mult_neg got cyc=%0d done=%b %h_%h want 5/1 ffffffff_ffffffeb", c, d, bus.HI, bus.LO);
    end
  endtask

  task automatic test_div();
    int c; logic d;
    run_op(3'b010, 32'hFFFFFFF9, 32'd2, c, d);
    vectors++;
    if (c !== 10 || d !== 1'b1) begin
      miscompares++; $display("FAIL div_busy got cycles=%0d done=%b want 10/1", c, d);
    end
    vectors++;
    if (bus.LO !== 32'hFFFFFFFD || bus.HI !== 32'hFFFFFFFF) begin
      miscompares++; $display("FAIL div_result got HI=%h LO=%h want ffffffff fffffffd", bus.HI, bus.LO);
    end
    run_op(3'b011, 32'd100, 32'd7, c, d);
    vectors++;
    if (bus.LO !== 32'd14 || bus.HI !== 32'd2) begin
      miscompares++; $display("FAIL divu_result got HI=%h LO=%h want 2 e", bus.HI, bus.LO);
    end
  endtask

  task automatic test_div_boundary();
    int c; logic d;
    run_op(3'b011, 32'h12345678, 32'h0, c, d);
    vectors++;
    if (bus.LO !== 32'hFFFFFFFF || bus.HI !== 32'h12345678) begin
      miscompares++; $display("FAIL divu_zero got HI=%h LO=%h want 12345678 ffffffff", bus.HI, bus.LO);
    end
    run_op(3'b010, 32'hFFFFFFFB, 32'h0, c, d);
    vectors++;
    if (bus.LO !== 32'hFFFFFFFF || bus.HI !== 32'hFFFFFFFB) begin
      miscompares++; $display("FAIL div_zero got HI=%h LO=%h want fffffffb ffffffff", bus.HI, bus.LO);
    end
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, c, d);
    vectors++;
    if (bus.LO !== 32'h80000000 || bus.HI !== 32'h0) begin
      miscompares++; $display("FAIL div_ovf got HI=%h LO=%h want 0 80000000", bus.HI, bus.LO);
    end
  endtask

  task automatic test_mtlo();
    bus.start = 1'b1; bus.op = 3'b101; bus.A = 32'hA5A5A5A5; bus.B = 32'h0;
    @(posedge clk); #1 bus.start = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.LO !== 32'hA5A5A5A5 || bus.HI !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL mtlo got LO=%h HI=%h busy=%b done=%b want a5a5a5a5 0 0 0",
               bus.LO, bus.HI, bus.busy, bus.done);
    end
  endtask

  task automatic test_mthi_ignored();
    int c;
    bus.start = 1'b1; bus.op = 3'b000; bus.A = 32'h00010000; bus.B = 32'h00030000;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 3'b100; bus.A = 32'h1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.HI !== 32'h0 || bus.busy !== 1'b1) begin
      miscompares++; $display("FAIL mthi_busy got HI=%h busy=%b want 0 1", bus.HI, bus.busy);
    end
    c = 0;
    while (bus.busy && c < 40) begin @(negedge clk); c++; end
    vectors++;
    if (bus.HI !== 32'h3 || bus.LO !== 32'h0 || bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL mthi_ignored got HI=%h LO=%h done=%b want 3 0 1", bus.HI, bus.LO, bus.done);
    end
  endtask

  task automatic test_back_to_back();
    int c; logic d;
    run_op(3'b001, 32'd2, 32'd3, c, d);
    run_op(3'b001, 32'd4, 32'd5, c, d);
    vectors++;
    if (c !== 5 || d !== 1'b1 || bus.LO !== 32'd20 || bus.HI !== 32'd0) begin
      miscompares++;
      $display("FAIL back_to_back got cyc=%0d done=%b HI=%h LO=%h want 5/1 0 14", c, d, bus.HI, bus.LO);
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    bus.start = 1'b1; bus.op = 3'b011; bus.A = 32'd100; bus.B = 32'd7;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.HI !== 32'h0 || bus.LO !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_abort got busy=%b HI=%h LO=%h want 0 0 0", bus.busy, bus.HI, bus.LO);
    end
    #2 reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy || bus.HI !== 32'h0 || bus.LO !== 32'h0) dones++;
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++; $display("FAIL reset_no_commit got %0d bad cycles want 0", dones);
    end
  endtask

  task automatic test_narrow();
    int c;
    bus8.start = 1'b1; bus8.op = 3'b000; bus8.A = 8'h80; bus8.B = 8'h80;
    @(posedge clk); #1 bus8.start = 1'b0;
    c = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus8.busy) c++;
      else break;
    end
    vectors++;
    if (c !== 1 || bus8.done !== 1'b1) begin
      miscompares++; $display("FAIL narrow_busy got cycles=%0d done=%b want 1/1", c, bus8.done);
    end
    vectors++;
    if (bus8.HI !== 8'h40 || bus8.LO !== 8'h00) begin
      miscompares++; $display("FAIL narrow_mult got HI=%h LO=%h want 40 00", bus8.HI, bus8.LO);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    bus.start = 1'b0; bus.op = 3'b111; bus.A = '0; bus.B = '0;
    bus8.start = 1'b0; bus8.op = 3'b111; bus8.A = '0; bus8.B = '0;
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_boundary();
    test_mtlo();
    test_mthi_ignored();
    test_back_to_back();
    test_reset_abort();
    test_narrow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
